// File: rtl/bram_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_pipe_if
// Brief    : Access bus of bram_pipe: shared address, byte-enabled write,
//            read request and registered read return.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   din;
    logic                we;
    logic [DATA_W/8-1:0] be;
    logic                startReadRAM;
    logic [DATA_W-1:0]   out;
    logic                readRdyRAM;
    logic                saveRdyRAM;

    modport master (
        output addr, din, we, be, startReadRAM,
        input  out, readRdyRAM, saveRdyRAM
    );

    modport slave (
        input  addr, din, we, be, startReadRAM,
        output out, readRdyRAM, saveRdyRAM
    );
endinterface
`default_nettype wire

// File: rtl/bram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram_pipe
// Brief    : Single-port byte-writable block RAM with post-reset zero fill and
//            a pipelined read return of 1 or 2 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module bram_pipe #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 3584,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int WR_FWD         = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bram_pipe_if.slave    bus
);
    localparam int              c_NB   = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_save_rdy;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_out;
    logic                r_rdy;

    logic                w_in_range;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rd_word;

    assign w_in_range = (32'(bus.addr) < 32'(DEPTH));
    assign w_wr_ok    = r_save_rdy & bus.we & w_in_range;
    assign w_rd_ok    = r_save_rdy & bus.startReadRAM;
    assign w_old      = w_in_range ? r_mem[bus.addr] : '0;

    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < c_NB; b++) begin
            if (bus.be[b]) begin
                w_merged[8*b +: 8] = bus.din[8*b +: 8];
            end
        end
    end

    // Out-of-range reads return zero; write-first only applies to an accepted write.
    assign w_rd_word = !w_in_range                    ? '0       :
                       ((WR_FWD != 0) && w_wr_ok)     ? w_merged : w_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_clr_addr <= '0;
            r_save_rdy <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_addr == c_LAST) begin
                        r_state    <= ST_READY;
                        r_save_rdy <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                ST_READY: begin
                    r_save_rdy <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_addr] <= '0;
            end else if (w_wr_ok) begin
                for (int b = 0; b < c_NB; b++) begin
                    if (bus.be[b]) begin
                        r_mem[bus.addr][8*b +: 8] <= bus.din[8*b +: 8];
                    end
                end
            end
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out <= '0;
                    r_rdy <= 1'b0;
                end else begin
                    r_rdy <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_out <= w_rd_word;
                    end
                end
            end
        end else begin : g_lat2
            logic              r_p1_vld;
            logic [DATA_W-1:0] r_p1_dat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_p1_vld <= 1'b0;
                    r_p1_dat <= '0;
                    r_out    <= '0;
                    r_rdy    <= 1'b0;
                end else begin
                    r_p1_vld <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_p1_dat <= w_rd_word;
                    end
                    r_rdy <= r_p1_vld;
                    if (r_p1_vld) begin
                        r_out <= r_p1_dat;
                    end
                end
            end
        end
    endgenerate

    assign bus.out        = r_out;
    assign bus.readRdyRAM = r_rdy;
    assign bus.saveRdyRAM = r_save_rdy;
endmodule
`default_nettype wire

// File: tb/tb_bram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_pipe
// Brief    : Drives a read-first/latency-1 and a write-first/latency-2 instance
//            with identical traffic and checks both against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_pipe;
    localparam int c_DEPTH = 3584;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_pipe_if #(.DATA_W(32), .ADDR_W(12)) if_a ();
    bram_pipe_if #(.DATA_W(32), .ADDR_W(12)) if_b ();

    bram_pipe #(.READ_LAT(1), .WR_FWD(0)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    bram_pipe #(.READ_LAT(2), .WR_FWD(1)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_mem [c_DEPTH];
    int          m_cnt   = 0;
    bit          m_ready = 1'b0;
    int          ecnt    = 0;
    rd_t         q_a[$];
    rd_t         q_b[$];
    logic [31:0] last_a = '0, last_b = '0;
    bit          exp_rdy_a, exp_rdy_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] res = old;
        for (int i = 0; i < 4; i++) if (b[i]) res[8*i +: 8] = d[8*i +: 8];
        return res;
    endfunction

    // Model of one rising edge: what memory, strobes and ready become afterwards.
    task automatic model(input bit r, input bit w, input bit rd, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        int          e = ecnt + 1;
        bit          inr = (int'(a) < c_DEPTH);
        logic [31:0] old, nw;
        ecnt = e;
        if (r) begin
            q_a.delete(); q_b.delete();
            last_a = '0; last_b = '0;
            m_ready = 1'b0; m_cnt = 0;
            exp_rdy_a = 1'b0; exp_rdy_b = 1'b0;
            return;
        end
        old = inr ? m_mem[a] : 32'h0;
        nw  = merge(old, d, b);
        if (m_ready) begin
            if (rd) begin
                q_a.push_back('{due: e,     dat: old});
                q_b.push_back('{due: e + 1, dat: (inr && w) ? nw : old});
            end
            if (w && inr) m_mem[a] = nw;
        end else begin
            m_mem[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == c_DEPTH) m_ready = 1'b1;
        end
        exp_rdy_a = 1'b0;
        if (q_a.size() > 0 && q_a[0].due == e) begin
            exp_rdy_a = 1'b1; last_a = q_a[0].dat; void'(q_a.pop_front());
        end
        exp_rdy_b = 1'b0;
        if (q_b.size() > 0 && q_b[0].due == e) begin
            exp_rdy_b = 1'b1; last_b = q_b[0].dat; void'(q_b.pop_front());
        end
    endtask

    task automatic cycle(input bit r, input bit w, input bit rd, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        rst = r;
        if_a.we = w; if_a.startReadRAM = rd; if_a.addr = a; if_a.din = d; if_a.be = b;
        if_b.we = w; if_b.startReadRAM = rd; if_b.addr = a; if_b.din = d; if_b.be = b;
        model(r, w, rd, a, d, b);
        @(posedge clk);
        #1;
        chk("save_a", 32'(if_a.saveRdyRAM), 32'(m_ready));
        chk("save_b", 32'(if_b.saveRdyRAM), 32'(m_ready));
        chk("rdy_a",  32'(if_a.readRdyRAM), 32'(exp_rdy_a));
        chk("rdy_b",  32'(if_b.readRdyRAM), 32'(exp_rdy_b));
        chk("out_a",  if_a.out, last_a);
        chk("out_b",  if_b.out, last_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0);
    endtask

    task automatic rnd(input int n);
        for (int i = 0; i < n; i++) begin
            int          sel = int'($urandom_range(0, 9));
            logic [11:0] a;
            if (sel < 6)      a = 12'($urandom_range(0, 31));
            else if (sel < 8) a = 12'($urandom_range(0, c_DEPTH - 1));
            else              a = 12'($urandom_range(c_DEPTH, 4095));
            cycle(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a,
                  $urandom, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 32'h0;
        if_a.we = 1'b0; if_a.startReadRAM = 1'b0; if_a.addr = '0; if_a.din = '0; if_a.be = '0;
        if_b.we = 1'b0; if_b.startReadRAM = 1'b0; if_b.addr = '0; if_b.din = '0; if_b.be = '0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 12'd5, 32'hDEAD_BEEF, 4'hF);
        chk("rst_out", if_a.out, 32'h0);

        // Traffic during the fill must be ignored.
        rnd(c_DEPTH);
        chk("ready_after_fill", 32'(if_a.saveRdyRAM), 32'd1);

        cycle(1'b0, 1'b0, 1'b1, 12'd3583, 32'd0, 4'd0);
        chk("last_word_zero", if_a.out, 32'h0);

        cycle(1'b0, 1'b1, 1'b1, 12'd7, 32'hFFFF_FFFF, 4'hF);
        chk("coll_a", if_a.out, 32'h0);
        idle(1);
        chk("coll_b", if_b.out, 32'hFFFF_FFFF);

        cycle(1'b0, 1'b1, 1'b0, 12'd5, 32'hAABB_CCDD, 4'hF);
        cycle(1'b0, 1'b1, 1'b0, 12'd5, 32'h1122_3344, 4'h5);
        cycle(1'b0, 1'b0, 1'b1, 12'd5, 32'd0, 4'd0);
        chk("byte_a", if_a.out, 32'hAA22_CC44);
        idle(1);
        chk("byte_b", if_b.out, 32'hAA22_CC44);

        for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 1'b0, 12'(i), 32'(i * 32'h0101_0101), 4'hF);
        for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b0, 1'b1, 12'(i), 32'd0, 4'd0);
        idle(3);

        cycle(1'b0, 1'b1, 1'b0, 12'd4000, 32'h5, 4'hF);
        cycle(1'b0, 1'b0, 1'b1, 12'd4000, 32'd0, 4'd0);
        chk("oor_a", if_a.out, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 12'd416, 32'd0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 12'd7, 32'd0, 4'd0);
        idle(2);

        rnd(600);

        // Read in flight on the latency-2 instance when reset hits.
        cycle(1'b0, 1'b0, 1'b1, 12'd7, 32'd0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0);
        chk("flush_b", 32'(if_b.readRdyRAM), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0);

        rnd(100);
        cycle(1'b1, 1'b1, 1'b1, 12'd3, 32'h1234_5678, 4'hF);
        chk("midclr_rst", 32'(if_a.saveRdyRAM), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 4'd0);
        rnd(c_DEPTH);
        rnd(200);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bram_pipe.md
BRAM_PIPE -- requirements
Module: bram_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 12, address width.
REQ-003 SHALL have parameter DEPTH, default 3584, number of words (14 blocks x 256); DEPTH <= 2^ADDR_W.
REQ-004 SHALL have parameter READ_LAT, default 1, read latency in cycles (legal values 1, 2).
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 means zero-fill the memory after reset.
REQ-006 SHALL have parameter WR_FWD, default 0; 0 means read-first, 1 means write-first on a same-address collision.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-009 SHALL have port addr, input, ADDR_W, word address shared by read and write.
REQ-010 SHALL have port din, input, DATA_W, write data.
REQ-011 SHALL have port we, input, 1, write request.
REQ-012 SHALL have port be, input, DATA_W/8, byte enables; bit i qualifies din[8i+7:8i].
REQ-013 SHALL have port startReadRAM, input, 1, read request.
REQ-014 SHALL have port out, output, DATA_W, registered read data.
REQ-015 SHALL have port readRdyRAM, output, 1, one-cycle strobe marking valid out.
REQ-016 SHALL have port saveRdyRAM, output, 1, high when writes and reads are accepted.

Function
REQ-017 SHALL implement a two-state FSM: CLEAR, READY.
REQ-018 SHALL, when CLEAR_ON_RESET=1, enter CLEAR on the first cycle after rst deasserts.
REQ-019 SHALL, in CLEAR, write 0 to one word per cycle, at addresses 0..DEPTH-1 in order, then go to READY; clearing takes exactly DEPTH cycles.
REQ-020 SHALL, when CLEAR_ON_RESET=0, enter READY directly after reset; initial memory contents are then unspecified.
REQ-021 SHALL hold saveRdyRAM=0 in CLEAR and saveRdyRAM=1 in READY; we and startReadRAM are ignored while saveRdyRAM=0.
REQ-022 SHALL, in READY with we=1, update only the bytes whose be bit is 1 at addr on that edge; be=0 means no change.
REQ-023 SHALL, in READY with startReadRAM=1, sample addr and drive out with the word and readRdyRAM=1 exactly READ_LAT cycles later, for one cycle.
REQ-024 SHALL accept one read per cycle, fully pipelined; back-to-back requests give back-to-back strobes in request order.
REQ-025 SHALL hold out at its last value while readRdyRAM=0.
REQ-026 SHALL, on we and startReadRAM to the same addr in the same cycle, return the pre-write word when WR_FWD=0, or the byte-merged new word when WR_FWD=1.
REQ-027 SHALL ignore writes with addr >= DEPTH and return 0 (with a normal strobe) for reads with addr >= DEPTH.

Reset
REQ-028 SHALL, while rst=1, force out=0, readRdyRAM=0, saveRdyRAM=0 and flush all in-flight reads, with no strobe for any of them.
REQ-029 SHALL, when rst is asserted during CLEAR, restart clearing from address 0 after release.
REQ-030 SHALL, when rst is asserted during READY, leave memory contents untouched except for re-clearing when CLEAR_ON_RESET=1.

Verification
REQ-031 Reset then clear: release rst with defaults -> saveRdyRAM=0 for 3584 cycles, then 1; a read of address 3583 returns 0.
REQ-032 Byte write: write 0xAABBCCDD to address 5 with be=0xF, then 0x11223344 with be=0x5 -> a read returns 0xAA22CC44 with readRdyRAM one cycle after the request (READ_LAT=1).
REQ-033 Pipeline: READ_LAT=2, reads of addresses 1, 2, 3 on consecutive cycles -> three consecutive strobes starting 2 cycles after the first request, in order.
REQ-034 Collision: address 7 holds 0x0; in one cycle write 0xFFFFFFFF with be=0xF and read address 7 -> out=0x0 with WR_FWD=0, out=0xFFFFFFFF with WR_FWD=1.
REQ-035 Reset mid-operation: assert rst at clear address 100 -> outputs 0; after release the clear restarts at address 0 and takes 3584 cycles. Assert rst with a read in flight -> no strobe is produced.
REQ-036 Out of range: ADDR_W=12, DEPTH=3584, write 0x5 to address 4000, then read it -> out=0 with a strobe, and no other word changes.
